serial_add_ctrl: RTL and testbench

//  Bit-serial add controller: sequences a single full_adder cell over WIDTH

---
 rtl/serial_add_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell is reused over WIDTH cycles, LSB first.
// Optional subtract path is enabled by defining SERIAL_SUB_EN.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    logic w_unused;
    assign w_unused = sub;
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // New sum bit enters at the MSB so the LSB-first result lands in place.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_res_next = w_s;
        end else begin : g_wn
            assign w_res_next = {w_s, r_res[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM with operand/result shifting and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_res   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= {CW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    // Last bit: carry into the MSB is r_carry, its carry out is w_co.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_co;
                        r_ovf   <= r_carry ^ w_co;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); follows SERIAL_SUB_EN if defined.
module tb_serial_add_ctrl;
    localparam int W = 8;
`ifdef SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic fc, input logic fs);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        logic [W-1:0] low;
        exp_t         e;
        bb = fb;
        cc = fc;
        if (fs && SUB_EN) begin
            bb = ~fb;
            cc = 1'b1;
        end
        full   = {1'b0, fa} + {1'b0, bb} + {{W{1'b0}}, cc};
        low    = {1'b0, fa[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cc};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = low[W-1] ^ full[W];
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        int           n;
        logic [W-1:0] prev;
        bit           stable;
        exp_t         e;
        @(posedge clk); #1;
        prev = sum; stable = 1'b1;
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        sb_q.push_back(model(ta, tb, tc, ts));
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b want 1", name, busy); end
        while (done !== 1'b1 && n < 40) begin
            if (sum !== prev) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != W + 1) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, W + 1); end
        checks++; if (!stable) begin errors++; $display("FAIL %s sum_stable got changed want held %h", name, prev); end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++; if (sum !== e.sum) begin errors++; $display("FAIL %s sum got %h want %h", name, sum, e.sum); end
            checks++; if (cout !== e.cout) begin errors++; $display("FAIL %s cout got %b want %b", name, cout, e.cout); end
            checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL %s ovf got %b want %b", name, ovf, e.ovf); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", name, done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got %b want 0", name, busy); end
    endtask

    task automatic test_add();
        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op("add_rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_sub();
        do_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            do_op("sub_rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_ignore_busy();
        int   ndone;
        exp_t e;
        ndone = 0;
        @(posedge clk); #1;
        a = 8'h33; b = 8'h44; cin = 1'b1; sub = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'h33, 8'h44, 1'b1, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1 && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checks++; if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                        errors++; $display("FAIL ignore_result got %h/%b/%b want %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        @(posedge clk); #1;
        a = 8'h21; b = 8'h43; cin = 1'b0; sub = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'h21, 8'h43, 1'b0, 1'b0));
        @(posedge clk); #1;
        a = 8'hC8; b = 8'h64; cin = 1'b1;
        sb_q.push_back(model(8'hC8, 8'h64, 1'b1, 1'b0));
        n = 1;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n != W + 1) begin errors++; $display("FAIL b2b_lat1 got %0d want %0d", n, W + 1); end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++; if (sum !== e.sum || cout !== e.cout) begin errors++; $display("FAIL b2b_res1 got %h/%b want %h/%b", sum, cout, e.sum, e.cout); end
        end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept2 got %b want 1", busy); end
        n = 2;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n != W + 2) begin errors++; $display("FAIL b2b_interval got %0d want %0d", n, W + 2); end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++; if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                errors++; $display("FAIL b2b_res2 got %h/%b/%b want %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        @(posedge clk); #1;
        a = 8'h9C; b = 8'h5B; cin = 1'b0; sub = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'h9C, 8'h5B, 1'b0, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
        checks++; if ({sum, cout, ovf} !== {8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstmid_outs got %h/%b/%b want 00/0/0", sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
        do_op("after_reset", 8'h9C, 8'h5B, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
